ball_ctl: RTL
=============

# ball_ctl

Ball motion controller for the Arkanoid game, sitting directly downstream of the paddle controller. It consumes the paddle's registered position and the mouse left button. The ball rides on the paddle until launched, then moves diagonally one pixel per step tick, bouncing off the walls, the ceiling and the paddle. A single-cycle loss pulse is raised when the ball reaches the bottom edge, and the ball then returns to the paddle.

## Interface
Parameters:
- SCREEN_W, 800, visible width in pixels
- SCREEN_H, 600, visible height in pixels
- BALL_SIZE, 10, ball square edge in pixels
- PADDLE_W, 100, paddle width in pixels
- STEP_DIV, 100_000, pclk cycles per one-pixel step (17-bit counter)
- SPEEDUP_STEP, 2_000, divider decrement per paddle hit (macro build only)
- MIN_DIV, 20_000, divider floor (macro build only)

Ports:
- pclk  in  1  pixel clock, the only clock
- reset_n  in  1  asynchronous, active-low reset
- paddle_xpos  in  12  paddle left edge, in pixels
- paddle_ypos  in  12  paddle top edge, in pixels
- launch  in  1  mouse left button, level, synchronous to pclk
- ball_xpos  out  12  ball left edge, registered
- ball_ypos  out  12  ball top edge, registered
- ball_active  out  1  high while in MOVE
- ball_lost  out  1  one-cycle pulse on loss

## Operation
- **States:** HOLD, MOVE and LOST. Reset enters HOLD.
- **HOLD:**
  - Ball position each cycle: ball_xpos = paddle_xpos + PADDLE_W/2 − BALL_SIZE/2 and ball_ypos = paddle_ypos − BALL_SIZE.
  - Arithmetic is 12-bit unsigned and wraps.
  - A rising edge of launch (launch=1 while launch_q=0) moves the block to MOVE with dx=+1 (right) and dy=−1 (up).
  - The tick counter is loaded with the current divider minus 1.
  - launch held high from reset does not launch; only an edge does.
- **MOVE:**
  - The tick counter decrements every cycle.
  - At 0 a step occurs and the counter reloads with divider−1.
  - Within a step, direction updates are evaluated on the current position first, then position += updated (dx, dy).
- **Bounce rules in a step:**
  - Left wall: x==0 and dx=−1 sets dx=+1.
  - Right wall: x==SCREEN_W−BALL_SIZE and dx=+1 sets dx=−1.
  - Ceiling: y==0 and dy=−1 sets dy=+1.
  - Paddle: dy=+1, y+BALL_SIZE==paddle_ypos, x+BALL_SIZE>paddle_xpos and x<paddle_xpos+PADDLE_W sets dy=−1.
  - Corner cases (wall plus ceiling, or wall plus paddle) flip both components in the same step.
- **Loss:** in a step with dy=+1 and y==SCREEN_H−BALL_SIZE, the position is not updated and the block goes to LOST.
- **LOST:** lasts exactly one cycle with ball_lost=1, then HOLD. The divider is restored to STEP_DIV.
- launch is ignored in MOVE and LOST.

## Timing
- **Reset values:**
  - ball_xpos = SCREEN_W/2 − BALL_SIZE/2 (395)
  - ball_ypos = 0
  - ball_active = 0, ball_lost = 0
  - state HOLD, launch_q = 0, dx=+1, dy=−1, divider = STEP_DIV
- **HOLD tracking:** ball outputs follow paddle inputs with 1-cycle latency.
- **Launch:** the edge in cycle N gives ball_active=1 at N+1. The first step lands at N+1+divider, after which the position has changed by (+1, −1).
- **Step period:** exactly divider cycles between position updates.
- **ball_lost:** asserted the cycle after the losing step, for one cycle. ball_active drops in that same cycle. HOLD tracking resumes the following cycle.
- **Reset mid-operation:** reset_n low forces the reset values immediately (asynchronous), and the counter is cleared.

## Configuration
- **BALL_SPEEDUP_EN defined:**
  - Every paddle bounce reduces the divider by SPEEDUP_STEP, saturating at MIN_DIV.
  - The reload at that step already uses the new divider.
  - Loss or reset restores STEP_DIV.
- **BALL_SPEEDUP_EN undefined:**
  - The divider is constant at STEP_DIV.
  - SPEEDUP_STEP and MIN_DIV are unused.

## Test plan
Benches use STEP_DIV=4, SPEEDUP_STEP=1 and MIN_DIV=2.
- **Reset and HOLD:**
  - Release reset_n with paddle_xpos=100, paddle_ypos=500 → 395/0 during reset.
  - One cycle later → ball_xpos=145, ball_ypos=490, ball_active=0.
- **Launch:**
  - Hold launch high through reset → no launch.
  - Drop and re-raise launch at cycle N → ball_active=1 at N+1.
  - Position (146, 489) at N+5, then (147, 488) at N+9.
- **Right wall plus ceiling corner:**
  - Place the ball at (790, 0) moving (+1, −1) → next step gives (789, 1) with direction (−1, +1).
- **Paddle bounce:**
  - Ball at (150, 490) moving (+1, +1), paddle_xpos=100, paddle_ypos=500 → next position (151, 489) with dy=−1.
  - With BALL_SPEEDUP_EN, the following step interval is 3 cycles.
- **Loss:**
  - Paddle moved away (paddle_xpos=600) and the ball falls to y=590 → next step raises ball_lost for exactly one cycle.
  - Then the block is in HOLD tracking the paddle and the divider is back to 4.
- **Reset mid-flight:**
  - Assert reset_n low in MOVE between steps → outputs are 395/0/0/0 in the same cycle with no clock edge needed.

Source files
------------

// File: rtl/ball_ctl.sv
// ball_ctl: ball motion controller for the Arkanoid game.
// The ball rides on the paddle (HOLD) until a rising edge of the mouse
// button launches it (MOVE). It then moves one pixel diagonally per step
// tick and bounces off the side walls, the ceiling and the paddle. Reaching
// the bottom edge raises a one-cycle loss pulse (LOST), after which the
// ball returns to the paddle.
// Optional build macro: BALL_SPEEDUP_EN -- every paddle bounce shortens
// the step period by SPEEDUP_STEP cycles, never below MIN_DIV.
module ball_ctl #(
    parameter int SCREEN_W     = 800,
    parameter int SCREEN_H     = 600,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 100,
    parameter int STEP_DIV     = 100_000,
    parameter int SPEEDUP_STEP = 2_000,
    parameter int MIN_DIV      = 20_000
) (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic [11:0] paddle_xpos,
    input  logic [11:0] paddle_ypos,
    input  logic        launch,
    output logic [11:0] ball_xpos,
    output logic [11:0] ball_ypos,
    output logic        ball_active,
    output logic        ball_lost,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        MOVE = 2'd1,
        LOST = 2'd2
    } state_t;

`ifdef BALL_SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    // Geometry constants, all in the 12-bit wrapping pixel domain.
    localparam logic [11:0] HOLD_XOFF = 12'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic [11:0] BALL_H    = 12'(BALL_SIZE);
    localparam logic [11:0] PAD_W     = 12'(PADDLE_W);
    localparam logic [11:0] X_MAX     = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] Y_MAX     = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] X_RESET   = 12'(SCREEN_W / 2 - BALL_SIZE / 2);
    localparam logic [16:0] DIV_INIT  = 17'(STEP_DIV);
    localparam logic [16:0] DIV_STEP  = 17'(SPEEDUP_STEP);
    localparam logic [16:0] DIV_MIN   = 17'(MIN_DIV);

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        dx_right_q, dx_right_d;   // 1: moving right (+1), 0: left (-1)
    logic        dy_down_q, dy_down_d;     // 1: moving down (+1), 0: up (-1)
    logic [16:0] div_q, div_d;
    logic [16:0] cnt_q, cnt_d;
    logic        launch_q;
    // armed_q is set once the button has been seen released, so a button
    // held through reset cannot launch the ball on its own.
    logic        armed_q, armed_d;

    logic        launch_edge;
    logic        step;
    logic        paddle_hit;
    logic        ndx_right;
    logic        ndy_down;
    logic        lose;
    logic [16:0] div_sat;
    logic [16:0] div_next;

    assign launch_edge = launch & ~launch_q & armed_q;
    assign step        = (cnt_q == 17'd0);

    // Bounce evaluation on the current position; each rule looks at the
    // direction held before this step so corner hits flip both components.
    always_comb begin
        ndx_right  = dx_right_q;
        ndy_down   = dy_down_q;
        paddle_hit = 1'b0;
        if ((x_q == 12'd0) && !dx_right_q) begin
            ndx_right = 1'b1;
        end
        if ((x_q == X_MAX) && dx_right_q) begin
            ndx_right = 1'b0;
        end
        if ((y_q == 12'd0) && !dy_down_q) begin
            ndy_down = 1'b1;
        end
        if (dy_down_q && ((y_q + BALL_H) == paddle_ypos) &&
            ((x_q + BALL_H) > paddle_xpos) && (x_q < (paddle_xpos + PAD_W))) begin
            paddle_hit = 1'b1;
            ndy_down   = 1'b0;
        end
        lose = ndy_down && (y_q == Y_MAX);
    end

    // Divider update on a paddle hit: saturating decrement when speedup is on.
    always_comb begin
        div_sat  = (div_q >= (DIV_MIN + DIV_STEP)) ? (div_q - DIV_STEP) : DIV_MIN;
        div_next = div_q;
        if (SPEEDUP_ON && paddle_hit) begin
            div_next = div_sat;
        end
    end

    // Next-state and datapath update for HOLD / MOVE / LOST.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        dx_right_d = dx_right_q;
        dy_down_d  = dy_down_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        armed_d    = armed_q | ~launch;
        case (state_q)
            HOLD: begin
                x_d = paddle_xpos + HOLD_XOFF;
                y_d = paddle_ypos - BALL_H;
                if (launch_edge) begin
                    state_d    = MOVE;
                    dx_right_d = 1'b1;
                    dy_down_d  = 1'b0;
                    cnt_d      = div_q - 17'd1;
                end
            end
            MOVE: begin
                if (step) begin
                    dx_right_d = ndx_right;
                    dy_down_d  = ndy_down;
                    div_d      = div_next;
                    cnt_d      = div_next - 17'd1;
                    if (lose) begin
                        state_d = LOST;
                    end else begin
                        x_d = ndx_right ? (x_q + 12'd1) : (x_q - 12'd1);
                        y_d = ndy_down  ? (y_q + 12'd1) : (y_q - 12'd1);
                    end
                end else begin
                    cnt_d = cnt_q - 17'd1;
                end
            end
            LOST: begin
                state_d    = HOLD;
                div_d      = DIV_INIT;
                dx_right_d = 1'b1;
                dy_down_d  = 1'b0;
                x_d        = paddle_xpos + HOLD_XOFF;
                y_d        = paddle_ypos - BALL_H;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HOLD;
            x_q        <= X_RESET;
            y_q        <= 12'd0;
            dx_right_q <= 1'b1;
            dy_down_q  <= 1'b0;
            div_q      <= DIV_INIT;
            cnt_q      <= 17'd0;
            launch_q   <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dx_right_q <= dx_right_d;
            dy_down_q  <= dy_down_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            launch_q   <= launch;
            armed_q    <= armed_d;
        end
    end

    assign ball_xpos   = x_q;
    assign ball_ypos   = y_q;
    assign ball_active = (state_q == MOVE);
    assign ball_lost   = (state_q == LOST);
    assign state_dbg   = state_q;

endmodule
